// File: rtl/audio_sample_feeder_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : register map, FSM states and saturating volume scale
// Rev 1.0
// ============================================================================
package audio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_UNDERRUN = 2'd3;

  localparam logic [7:0]         VOL_UNITY = 8'd128;
  localparam logic signed [15:0] SAT_MAX   = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN   = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } frame_t;

  // Signed sample times unsigned volume; the 25-bit product cannot overflow.
  function automatic logic signed [15:0] scale_sat(input logic signed [15:0] sample,
                                                   input logic [7:0]         vol,
                                                   input int                 shift);
    logic signed [24:0] prod;
    prod = 25'(sample) * $signed({17'd0, vol});
    prod = prod >>> shift;
    if (prod > 25'(SAT_MAX)) return SAT_MAX;
    if (prod < 25'(SAT_MIN)) return SAT_MIN;
    return prod[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// audio_sample_feeder_if : Avalon-MM slave bus plus left/right sample streams
// Rev 1.0
// ============================================================================
interface audio_sample_feeder_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] left_data;
  logic [15:0] right_data;
  logic        left_valid;
  logic        right_valid;
  logic        left_ready;
  logic        right_ready;

  modport master (
    output chipselect, write, read, address, writedata, left_ready, right_ready,
    input  readdata, left_data, right_data, left_valid, right_valid
  );

  modport slave (
    input  chipselect, write, read, address, writedata, left_ready, right_ready,
    output readdata, left_data, right_data, left_valid, right_valid
  );
endinterface
`default_nettype wire

// File: rtl/audio_sample_feeder_fifo.sv
`default_nettype none
// ============================================================================
// sample_fifo : synchronous show-ahead FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic            push_ok, pop_ok;

  assign full  = (count_q == FULL_LEVEL);
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_sample_feeder.sv
`default_nettype none
// ============================================================================
// audio_sample_feeder : Avalon-MM sample FIFO feeding volume-scaled L/R streams
// Rev 1.0
// ============================================================================
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int VOL_SHIFT  = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  audio_sample_feeder_if.slave  bus
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en, rd_en, push, pop, load_silence;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  frame_t        fifo_frame;

  logic          enable_q, enable_d;
  logic [7:0]    volume_q, volume_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   underrun_q, underrun_d;
  logic [31:0]   readdata_q, readdata_d;
  state_e        state_q, state_d;
  logic [15:0]   left_q, left_d, right_q, right_d;
  logic          left_valid_q, left_valid_d, right_valid_q, right_valid_d;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.writedata),
    .rdata   (fifo_frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    wr_en      = bus.chipselect && bus.write;
    rd_en      = bus.chipselect && bus.read;
    push       = wr_en && (bus.address == ADDR_DATA);
    enable_d   = enable_q;
    volume_d   = volume_q;
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    readdata_d = readdata_q;

    if (push && fifo_full) overflow_d = 1'b1;
    if (wr_en && bus.address == ADDR_CTRL) begin
      enable_d = bus.writedata[0];
      volume_d = bus.writedata[15:8];
    end
    if (wr_en && bus.address == ADDR_STATUS) overflow_d = 1'b0;
    if (load_silence && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
    if (wr_en && bus.address == ADDR_UNDERRUN) underrun_d = '0;

    if (rd_en) begin
      case (bus.address)
        ADDR_CTRL:     readdata_d = {16'd0, volume_q, 7'd0, enable_q};
        ADDR_STATUS:   readdata_d = {21'd0, overflow_q, fifo_full, fifo_empty, 8'(fifo_level)};
        ADDR_UNDERRUN: readdata_d = {16'd0, underrun_q};
        default:       readdata_d = '0;
      endcase
    end
  end

  // Enable only gates starting a frame; a frame already popped always finishes.
  always_comb begin
    state_d       = state_q;
    left_d        = left_q;
    right_d       = right_q;
    left_valid_d  = left_valid_q;
    right_valid_d = right_valid_q;
    pop           = 1'b0;
    load_silence  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          left_d  = fifo_frame.left;
          right_d = fifo_frame.right;
          state_d = ST_SCALE;
        end else if (enable_q && bus.left_ready && bus.right_ready) begin
          load_silence  = 1'b1;
          left_d        = '0;
          right_d       = '0;
          left_valid_d  = 1'b1;
          right_valid_d = 1'b1;
          state_d       = ST_SEND;
        end
      end
      ST_SCALE: begin
        left_d        = scale_sat(left_q, volume_q, VOL_SHIFT);
        right_d       = scale_sat(right_q, volume_q, VOL_SHIFT);
        left_valid_d  = 1'b1;
        right_valid_d = 1'b1;
        state_d       = ST_SEND;
      end
      ST_SEND: begin
        if (left_valid_q && bus.left_ready)   left_valid_d  = 1'b0;
        if (right_valid_q && bus.right_ready) right_valid_d = 1'b0;
        if (!left_valid_d && !right_valid_d)  state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      volume_q      <= VOL_UNITY;
      overflow_q    <= 1'b0;
      underrun_q    <= '0;
      readdata_q    <= '0;
      state_q       <= ST_IDLE;
      left_q        <= '0;
      right_q       <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
    end else begin
      enable_q      <= enable_d;
      volume_q      <= volume_d;
      overflow_q    <= overflow_d;
      underrun_q    <= underrun_d;
      readdata_q    <= readdata_d;
      state_q       <= state_d;
      left_q        <= left_d;
      right_q       <= right_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.left_data   = left_q;
  assign bus.right_data  = right_q;
  assign bus.left_valid  = left_valid_q;
  assign bus.right_valid = right_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_feeder.sv
`default_nettype none
// ============================================================================
// tb_audio_sample_feeder : directed + randomized checks against a frame-queue model
// Rev 1.0
// ============================================================================
module tb_audio_sample_feeder;
  import audio_pkg::*;

  localparam int DEPTH = 16;
  localparam int VSH   = 7;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  audio_sample_feeder_if bus();

  audio_sample_feeder #(.FIFO_DEPTH(DEPTH), .VOL_SHIFT(VSH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  bit          exp_ovf = 1'b0;
  logic [15:0] left_got[$];
  logic [15:0] right_got[$];
  int          lv_cycles = 0;
  int          rv_cycles = 0;
  bit          l_hold = 1'b0, r_hold = 1'b0;
  logic [15:0] l_prev, r_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: floor((sample * vol) / 2^VSH), clamped to the 16-bit signed range.
  function automatic logic [15:0] ref_scale(input logic [15:0] raw, input int vol);
    int s, p;
    s = $signed(raw);
    p = s * vol;
    p = p >>> VSH;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = '0;
    s[7:0]  = 8'(exp_q.size());
    s[8]    = (exp_q.size() == 0);
    s[9]    = (exp_q.size() == DEPTH);
    s[10]   = exp_ovf;
    return s;
  endfunction

  function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
    if (q.size() > i) return q[i];
    return 'x;
  endfunction

  // Stream monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!reset_n) begin
      l_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (l_hold) begin
        check("l_hold_valid", {31'd0, bus.left_valid}, 32'd1);
        check("l_hold_data", {16'd0, bus.left_data}, {16'd0, l_prev});
      end
      if (r_hold) begin
        check("r_hold_valid", {31'd0, bus.right_valid}, 32'd1);
        check("r_hold_data", {16'd0, bus.right_data}, {16'd0, r_prev});
      end
      if (bus.left_valid)  lv_cycles++;
      if (bus.right_valid) rv_cycles++;
      if (bus.left_valid && bus.left_ready)   left_got.push_back(bus.left_data);
      if (bus.right_valid && bus.right_ready) right_got.push_back(bus.right_data);
      l_hold = bus.left_valid && !bus.left_ready;
      r_hold = bus.right_valid && !bus.right_ready;
      l_prev = bus.left_data;
      r_prev = bus.right_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = addr; bus.writedata = data;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = addr;
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    data = bus.readdata;
  endtask

  task automatic push_frame(input logic [31:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else exp_ovf = 1'b1;
    bus_write(ADDR_DATA, w);
  endtask

  task automatic clear_got();
    left_got.delete(); right_got.delete();
    lv_cycles = 0; rv_cycles = 0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (left_got.size() >= n && right_got.size() >= n) break;
      tick();
    end
    check("wait_frames", {31'd0, (left_got.size() >= n && right_got.size() >= n)}, 32'd1);
  endtask

  // Enable for exactly one IDLE evaluation so a single frame is released.
  task automatic single_frame(input logic [7:0] vol, input string tag);
    logic [31:0] w;
    clear_got();
    bus_write(ADDR_CTRL, {16'd0, vol, 8'h01});
    bus_write(ADDR_CTRL, {16'd0, vol, 8'h00});
    wait_got(1, 50);
    repeat (3) tick();
    w = exp_q.pop_front();
    check({tag, "_left"},  {16'd0, qget(left_got, 0)},  {16'd0, ref_scale(w[31:16], int'(vol))});
    check({tag, "_right"}, {16'd0, qget(right_got, 0)}, {16'd0, ref_scale(w[15:0], int'(vol))});
    check({tag, "_count"}, left_got.size() + right_got.size(), 32'd2);
  endtask

  // Drain the whole model queue; anything arriving after it must be silence.
  task automatic run_drain(input logic [7:0] vol, input bit rnd);
    int n, k;
    logic [31:0] w, rd;
    n = exp_q.size();
    clear_got();
    bus_write(ADDR_UNDERRUN, 32'd0);
    bus_write(ADDR_CTRL, {16'd0, vol, 8'h01});
    for (int c = 0; c < 2000; c++) begin
      if (left_got.size() >= n && right_got.size() >= n) break;
      bus.left_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.right_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    bus_write(ADDR_CTRL, {16'd0, vol, 8'h00});
    bus.left_ready = 1'b1; bus.right_ready = 1'b1;
    repeat (8) tick();
    check("drain_reached", {31'd0, (left_got.size() >= n && right_got.size() >= n)}, 32'd1);
    check("drain_lr_equal", left_got.size(), right_got.size());
    for (int i = 0; i < n; i++) begin
      w = exp_q[i];
      check("drain_left",  {16'd0, qget(left_got, i)},  {16'd0, ref_scale(w[31:16], int'(vol))});
      check("drain_right", {16'd0, qget(right_got, i)}, {16'd0, ref_scale(w[15:0], int'(vol))});
    end
    k = (left_got.size() > n) ? left_got.size() - n : 0;
    for (int i = n; i < left_got.size(); i++) begin
      check("drain_silence", {qget(left_got, i), qget(right_got, i)}, 32'd0);
    end
    exp_q.delete();
    bus_read(ADDR_UNDERRUN, rd);
    check("drain_underrun", rd, 32'(k));
    bus_read(ADDR_STATUS, rd);
    check("drain_status", rd, exp_status());
  endtask

  initial begin
    logic [31:0] rd, w;
    int n;
    logic [7:0] vol;

    reset_n = 1'b0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = 2'd0; bus.writedata = 32'd0;
    bus.left_ready = 1'b0; bus.right_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valids", {30'd0, bus.left_valid, bus.right_valid}, 32'd0);
    check("rst_data", {bus.left_data, bus.right_data}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    tick();

    bus_read(ADDR_CTRL, rd);     check("ctrl_reset", rd, 32'h0000_8000);
    bus_read(ADDR_STATUS, rd);   check("status_reset", rd, 32'h0000_0100);
    bus_read(ADDR_UNDERRUN, rd); check("underrun_reset", rd, 32'd0);

    // Unity volume passes samples through; valids last one cycle each.
    bus.left_ready = 1'b1; bus.right_ready = 1'b1;
    push_frame(32'h1234_EDCB);
    single_frame(8'd128, "unity");
    check("unity_left_const",  {16'd0, qget(left_got, 0)},  32'h0000_1234);
    check("unity_right_const", {16'd0, qget(right_got, 0)}, 32'h0000_EDCB);
    check("unity_lv_cycles", lv_cycles, 32'd1);
    check("unity_rv_cycles", rv_cycles, 32'd1);

    // Saturation in both directions at maximum volume.
    push_frame(32'h7000_9000);
    push_frame(32'h9000_7000);
    single_frame(8'd255, "sat_a");
    check("sat_a_pos", {16'd0, qget(left_got, 0)},  32'h0000_7FFF);
    check("sat_a_neg", {16'd0, qget(right_got, 0)}, 32'h0000_8000);
    single_frame(8'd255, "sat_b");
    check("sat_b_neg", {16'd0, qget(left_got, 0)},  32'h0000_8000);
    bus_read(ADDR_UNDERRUN, rd); check("no_underrun_yet", rd, 32'd0);

    // Overflow: 17 pushes while disabled.
    for (int i = 0; i < 17; i++) push_frame($urandom);
    bus_read(ADDR_STATUS, rd);
    check("ovf_status_model", rd, exp_status());
    check("ovf_status_const", rd, 32'h0000_0610);
    bus_write(ADDR_STATUS, 32'd0);
    exp_ovf = 1'b0;
    bus_read(ADDR_STATUS, rd);
    check("ovf_cleared", rd, 32'h0000_0210);
    run_drain(8'd128, 1'b0);

    // Five silence frames from an empty FIFO.
    clear_got();
    bus_write(ADDR_UNDERRUN, 32'd0);
    bus.left_ready = 1'b1; bus.right_ready = 1'b1;
    bus_write(ADDR_CTRL, 32'h0000_8001);
    for (int c = 0; c < 100; c++) begin
      if (left_got.size() >= 5) break;
      tick();
    end
    bus.left_ready = 1'b0; bus.right_ready = 1'b0;
    bus_write(ADDR_CTRL, 32'h0000_8000);
    repeat (4) tick();
    check("silence_left_n",  left_got.size(),  32'd5);
    check("silence_right_n", right_got.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check("silence_zero", {qget(left_got, i), qget(right_got, i)}, 32'd0);
    bus_read(ADDR_UNDERRUN, rd); check("underrun_five", rd, 32'd5);
    bus_write(ADDR_UNDERRUN, 32'd0);
    bus_read(ADDR_UNDERRUN, rd); check("underrun_clear", rd, 32'd0);

    // Independent channels: right stalls while left is accepted.
    clear_got();
    w = $urandom;
    push_frame(w);
    bus.left_ready = 1'b1; bus.right_ready = 1'b0;
    bus_write(ADDR_CTRL, 32'h0000_8001);
    bus_write(ADDR_CTRL, 32'h0000_8000);
    repeat (10) tick();
    void'(exp_q.pop_front());
    check("split_left_n", left_got.size(), 32'd1);
    check("split_right_n", right_got.size(), 32'd0);
    check("split_valids", {30'd0, bus.left_valid, bus.right_valid}, 32'd1);
    check("split_left_data", {16'd0, qget(left_got, 0)}, {16'd0, ref_scale(w[31:16], 128)});
    check("split_right_held", {16'd0, bus.right_data}, {16'd0, ref_scale(w[15:0], 128)});
    bus.right_ready = 1'b1;
    repeat (3) tick();
    check("split_right_n2", right_got.size(), 32'd1);
    check("split_right_data", {16'd0, qget(right_got, 0)}, {16'd0, ref_scale(w[15:0], 128)});

    // Randomized bursts with random volume and random backpressure.
    for (int r = 0; r < 4; r++) begin
      n   = $urandom_range(1, 16);
      vol = 8'($urandom_range(0, 255));
      for (int i = 0; i < n; i++) push_frame($urandom);
      run_drain(vol, 1'b1);
    end

    // Reset in the middle of SEND with four frames still queued.
    clear_got();
    for (int i = 0; i < 5; i++) push_frame($urandom);
    bus.left_ready = 1'b0; bus.right_ready = 1'b0;
    bus_write(ADDR_CTRL, 32'h0000_8001);
    bus_write(ADDR_CTRL, 32'h0000_8000);
    for (int c = 0; c < 20; c++) begin
      if (bus.left_valid) break;
      tick();
    end
    check("send_reached", {31'd0, bus.left_valid}, 32'd1);
    void'(exp_q.pop_front());
    bus_read(ADDR_STATUS, rd);
    check("send_level4", rd, exp_status());
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_valids", {30'd0, bus.left_valid, bus.right_valid}, 32'd0);
    check("async_rst_data", {bus.left_data, bus.right_data}, 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_got();
    bus_read(ADDR_CTRL, rd);   check("post_rst_ctrl", rd, 32'h0000_8000);
    bus_read(ADDR_STATUS, rd); check("post_rst_status", rd, exp_status());
    bus.left_ready = 1'b1; bus.right_ready = 1'b1;
    repeat (5) tick();
    check("post_rst_no_valid", lv_cycles + rv_cycles, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
